// File: rtl/vga_timing_gen_if.sv
// Pixel-source and DAC-side signals of the VGA timing generator.
// The master modport belongs to the generator; the slave modport is the source/DAC side.
interface vga_timing_gen_if #(
  parameter int COLOR_W = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic               en_i;
  logic [COLOR_W-1:0] R_i;
  logic [COLOR_W-1:0] G_i;
  logic [COLOR_W-1:0] B_i;
  logic               req_o;
  logic [X_W-1:0]     x_o;
  logic [Y_W-1:0]     y_o;
  logic [COLOR_W-1:0] R_o;
  logic [COLOR_W-1:0] G_o;
  logic [COLOR_W-1:0] B_o;
  logic               H_SYNC_o;
  logic               V_SYNC_o;
  logic               BLANK_o;
  logic               frame_start_o;

  modport master (
    input  en_i, R_i, G_i, B_i,
    output req_o, x_o, y_o, R_o, G_o, B_o, H_SYNC_o, V_SYNC_o, BLANK_o, frame_start_o
  );

  modport slave (
    output en_i, R_i, G_i, B_i,
    input  req_o, x_o, y_o, R_o, G_o, B_o, H_SYNC_o, V_SYNC_o, BLANK_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, pixel requests, and RGB/sync outputs
// delayed by the pixel-source read latency so everything leaves the block aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int COLOR_W  = 8,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      RD_LAT < 0 || RD_LAT > 7) begin : g_bad_params
    $error("vga_timing_gen: porch/sync parameters must be >= 1 and RD_LAT in 0..7");
  end

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } dec_t;

  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  dec_t           dec_now;
  dec_t           dec_tail;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (bus.en_i) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign bus.x_o   = h;
  assign bus.y_o   = v;
  assign bus.req_o = (h < H_ACT_END) && (v < V_ACT_END);

  assign dec_now.act   = bus.req_o;
  assign dec_now.hs    = (h >= HS_BEG) && (h < HS_END);
  assign dec_now.vs    = (v >= VS_BEG) && (v < VS_END);
  assign dec_now.first = (h == '0) && (v == '0);

  // Delay the decode by RD_LAT enabled edges to meet the source's returning data.
  if (RD_LAT == 0) begin : g_no_delay
    assign dec_tail = dec_now;
  end else begin : g_delay
    dec_t [RD_LAT-1:0] pipe;

    // NOTE: the delay line is reset, not left as uninitialised storage, so blanking and
    // inactive syncs are guaranteed for the first RD_LAT outputs after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe <= '0;
      end else if (bus.en_i) begin
        pipe[0] <= dec_now;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dec_tail = pipe[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.R_o           <= '0;
      bus.G_o           <= '0;
      bus.B_o           <= '0;
      bus.H_SYNC_o      <= ~HS_ON;
      bus.V_SYNC_o      <= ~VS_ON;
      bus.BLANK_o       <= 1'b1;
      bus.frame_start_o <= 1'b0;
    end else begin
      // Pulse lasts one clk even when the enable is sparse.
      bus.frame_start_o <= bus.en_i & dec_tail.first;
      if (bus.en_i) begin
        bus.R_o      <= dec_tail.act ? bus.R_i : '0;
        bus.G_o      <= dec_tail.act ? bus.G_i : '0;
        bus.B_o      <= dec_tail.act ? bus.B_i : '0;
        bus.H_SYNC_o <= dec_tail.hs ? HS_ON : ~HS_ON;
        bus.V_SYNC_o <= dec_tail.vs ? VS_ON : ~VS_ON;
        bus.BLANK_o  <= ~dec_tail.act;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 14x7 raster with a two-cycle source latency.
// Expected outputs come from frame-position arithmetic on the count of enabled edges.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int CW = 8;
  localparam int RD_LAT = 2;
  localparam int H_POL = 0;
  localparam int V_POL = 1;
  localparam bit HPOL_B = (H_POL != 0);
  localparam bit VPOL_B = (V_POL != 0);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(CW), .X_W(XW), .Y_W(YW)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(H_POL), .V_POL(V_POL), .COLOR_W(CW), .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3*CW-1:0] rgb;
    logic            blank;
    logic            hs;
    logic            vs;
    logic            fs;
    logic            req;
    int              x;
    int              y;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            last;
  logic [3*CW-1:0] color_of [FRAME];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              k = 0;
  bit              mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs seen after kn enabled edges since reset release.
  function automatic exp_t model_out(input int kn);
    exp_t e;
    int   c, q, h, v;
    bit   act;
    c     = kn % FRAME;
    e.x   = c % HT;
    e.y   = c / HT;
    e.req = (e.x < HA) && (e.y < VA);
    q     = kn - RD_LAT - 1;
    if (q < 0) begin
      e.rgb = '0; e.blank = 1'b1; e.hs = !HPOL_B; e.vs = !VPOL_B; e.fs = 1'b0;
    end else begin
      q       = q % FRAME;
      h       = q % HT;
      v       = q / HT;
      act     = (h < HA) && (v < VA);
      e.rgb   = act ? color_of[q] : '0;
      e.blank = !act;
      e.hs    = (h >= HA + HFP && h < HA + HFP + HS) ? HPOL_B : !HPOL_B;
      e.vs    = (v >= VA + VFP && v < VA + VFP + VS) ? VPOL_B : !VPOL_B;
      e.fs    = (q == 0);
    end
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, " rgb"},   64'({bus.R_o, bus.G_o, bus.B_o}), 64'(e.rgb));
    check({tag, " blank"}, 64'(bus.BLANK_o),       64'(e.blank));
    check({tag, " hsync"}, 64'(bus.H_SYNC_o),      64'(e.hs));
    check({tag, " vsync"}, 64'(bus.V_SYNC_o),      64'(e.vs));
    check({tag, " fstart"}, 64'(bus.frame_start_o), 64'(e.fs));
    check({tag, " x"},     64'(bus.x_o),           64'(e.x));
    check({tag, " y"},     64'(bus.y_o),           64'(e.y));
    check({tag, " req"},   64'(bus.req_o),         64'(e.req));
  endtask

  // mode 0: always enabled, 1: one clock in four, 2: random enable.
  task automatic run(input int cycles, input int mode);
    bit en;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      case (mode)
        0:       en = 1'b1;
        1:       en = (i % 4 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      if (en && k >= RD_LAT) {bus.R_i, bus.G_i, bus.B_i} = color_of[(k - RD_LAT) % FRAME];
      else                   {bus.R_i, bus.G_i, bus.B_i} = 24'($urandom);
      if (en) begin
        exp_q.push_back(model_out(k + 1));
        k++;
      end
      bus.en_i = en;
    end
  endtask

  always begin : monitor
    exp_t e;
    bit   en_s;
    @(posedge clk);
    en_s = bus.en_i;
    #1;
    if (mon_on) begin
      if (en_s) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          compare_all($sformatf("out t=%0t", $time), e);
          last = e;
        end
      end else begin
        e    = last;
        e.fs = 1'b0;
        compare_all($sformatf("hold t=%0t", $time), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < FRAME; i++) color_of[i] = 24'($urandom);
    rst_n    = 1'b0;
    bus.en_i = 1'b0;
    {bus.R_i, bus.G_i, bus.B_i} = '1;
    #23;
    compare_all("reset_init", model_out(0));

    @(negedge clk);
    rst_n  = 1'b1;
    k      = 0;
    last   = model_out(0);
    mon_on = 1'b1;

    run(250, 0);
    run(440, 1);
    run(400, 2);

    @(negedge clk);
    bus.en_i = 1'b0;
    @(negedge clk);
    mon_on = 1'b0;
    check("queue_empty_before_reset", 64'(exp_q.size()), 64'd0);
    #2 rst_n = 1'b0;
    #1 compare_all("mid_reset", model_out(0));
    @(negedge clk);
    rst_n  = 1'b1;
    k      = 0;
    last   = model_out(0);
    mon_on = 1'b1;

    run(300, 2);
    run(120, 0);

    @(negedge clk);
    bus.en_i = 1'b0;
    @(negedge clk);
    mon_on = 1'b0;
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
